// File: rtl/uart_boot_loader_if.sv
// Program-memory write bus driven by the UART boot loader.
interface uart_boot_loader_if #(
    parameter int ADDR_W = 32
);
    logic              mem_write_enable;
    logic [ADDR_W-1:0] mem_byte_address;
    logic [31:0]       mem_write_data;

    modport master (
        output mem_write_enable,
        output mem_byte_address,
        output mem_write_data
    );

    modport slave (
        input mem_write_enable,
        input mem_byte_address,
        input mem_write_data
    );
endinterface

// File: rtl/uart_boot_loader.sv
// Receives a length/payload/checksum image over 8N1 UART, writes it into program
// memory word by word and releases the core from reset once the image checks out.
module uart_boot_loader #(
    parameter int                CLKS_PER_BIT = 434,
    parameter int                ADDR_W       = 32,
    parameter logic [ADDR_W-1:0] BASE_ADDR    = '0,
    parameter int                MAX_WORDS    = 1024
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic                   io_rx,
    uart_boot_loader_if.master     mem,
    output logic                   cpu_reset_n,
    output logic                   load_done,
    output logic                   load_error
);
    localparam int             CW      = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CW-1:0]  HALF_M1 = CW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CW-1:0]  BIT_M1  = CW'(CLKS_PER_BIT - 1);

    typedef enum logic [1:0] {RX_IDLE, RX_START, RX_BITS, RX_STOP} rx_state_t;
    typedef enum logic [2:0] {LEN_LO, LEN_HI, DATA, CHECK, DONE, ERROR} state_t;

    rx_state_t   rx_state;
    logic        rx_meta, rx_sync, rx_prev;
    logic [CW-1:0] rx_cnt;
    logic [2:0]  rx_bit;
    logic [7:0]  rx_shift;
    logic        rx_valid, rx_ferr;

    state_t            state;
    logic [7:0]        len_lo;
    logic [15:0]       len_word;
    logic [15:0]       n_words, word_idx;
    logic [1:0]        lane;
    logic [23:0]       word_buf;
    logic [7:0]        csum;
    logic [ADDR_W-1:0] next_addr;

    assign len_word = {rx_shift, len_lo};

    // rx_shift is stable in RX_IDLE, so it doubles as the received byte while rx_valid is high.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rx_meta  <= 1'b1;
            rx_sync  <= 1'b1;
            rx_prev  <= 1'b1;
            rx_state <= RX_IDLE;
            rx_cnt   <= '0;
            rx_bit   <= '0;
            rx_shift <= '0;
            rx_valid <= 1'b0;
            rx_ferr  <= 1'b0;
        end else begin
            rx_meta  <= io_rx;
            rx_sync  <= rx_meta;
            rx_prev  <= rx_sync;
            rx_valid <= 1'b0;
            rx_ferr  <= 1'b0;
            case (rx_state)
                RX_IDLE: begin
                    if (rx_prev && !rx_sync) begin
                        rx_state <= RX_START;
                        rx_cnt   <= '0;
                    end
                end
                RX_START: begin
                    if (rx_cnt == HALF_M1) begin
                        rx_cnt <= '0;
                        rx_bit <= '0;
                        rx_state <= rx_sync ? RX_IDLE : RX_BITS;
                    end else begin
                        rx_cnt <= rx_cnt + 1'b1;
                    end
                end
                RX_BITS: begin
                    if (rx_cnt == BIT_M1) begin
                        rx_cnt   <= '0;
                        rx_shift <= {rx_sync, rx_shift[7:1]};
                        if (rx_bit == 3'd7) rx_state <= RX_STOP;
                        else                rx_bit   <= rx_bit + 1'b1;
                    end else begin
                        rx_cnt <= rx_cnt + 1'b1;
                    end
                end
                RX_STOP: begin
                    if (rx_cnt == BIT_M1) begin
                        rx_cnt   <= '0;
                        rx_state <= RX_IDLE;
                        rx_valid <= rx_sync;
                        rx_ferr  <= !rx_sync;
                    end else begin
                        rx_cnt <= rx_cnt + 1'b1;
                    end
                end
                default: rx_state <= RX_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state                <= LEN_LO;
            len_lo               <= '0;
            n_words              <= '0;
            word_idx             <= '0;
            lane                 <= '0;
            word_buf             <= '0;
            csum                 <= '0;
            next_addr            <= BASE_ADDR;
            mem.mem_write_enable <= 1'b0;
            mem.mem_byte_address <= '0;
            mem.mem_write_data   <= '0;
            cpu_reset_n          <= 1'b0;
            load_done            <= 1'b0;
            load_error           <= 1'b0;
        end else begin
            mem.mem_write_enable <= 1'b0;
            if (rx_ferr && state != DONE && state != ERROR) begin
                state      <= ERROR;
                load_error <= 1'b1;
            end else if (rx_valid) begin
                case (state)
                    LEN_LO: begin
                        len_lo <= rx_shift;
                        state  <= LEN_HI;
                    end
                    LEN_HI: begin
                        n_words <= len_word;
                        if (len_word == 16'd0) begin
                            state <= CHECK;
                        end else if (int'(len_word) > MAX_WORDS) begin
                            state      <= ERROR;
                            load_error <= 1'b1;
                        end else begin
                            state <= DATA;
                        end
                    end
                    DATA: begin
                        csum     <= csum ^ rx_shift;
                        lane     <= lane + 1'b1;
                        word_buf <= {rx_shift, word_buf[23:8]};
                        if (lane == 2'd3) begin
                            mem.mem_write_enable <= 1'b1;
                            mem.mem_write_data   <= {rx_shift, word_buf};
                            mem.mem_byte_address <= next_addr;
                            next_addr            <= next_addr + ADDR_W'(4);
                            word_idx             <= word_idx + 1'b1;
                            if (word_idx == n_words - 16'd1) state <= CHECK;
                        end
                    end
                    CHECK: begin
                        if (rx_shift == csum) begin
                            state       <= DONE;
                            load_done   <= 1'b1;
                            cpu_reset_n <= 1'b1;
                        end else begin
                            state      <= ERROR;
                            load_error <= 1'b1;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end
endmodule
